// File: rtl/ddr4_axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator for DDR4 bring-up.
// Writes a seeded pattern in INCR bursts, reads it back and counts errors.
module ddr4_axi_traffic_gen #(
  parameter int                DATA_W     = 256,
  parameter int                ADDR_W     = 31,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]       SEED       = 32'hA5A5_0000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic                calib_done,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         first_err_beat,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int                LANES        = DATA_W / 32;
  localparam int                BEAT_BYTES   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_LEN * BEAT_BYTES);
  localparam logic [2:0]        AX_SIZE      = 3'($clog2(BEAT_BYTES));
  localparam logic [7:0]        AX_LEN       = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST   = 16'(NUM_BURSTS - 1);
  localparam logic [15:0]       BURST_BEATS  = 16'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAL, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          beat;
  logic [15:0]         gbeat;
  logic [15:0]         burst_idx;
  logic                err_seen;

  logic                w_hs, b_hs, r_hs;
  logic                last_beat, last_burst;
  logic                data_err, rresp_err, rlast_err;
  logic [1:0]          err_add;
  logic [15:0]         err_beat;
  logic [16:0]         err_sum;
  logic [DATA_W-1:0]   beat_pattern;

  // Lane k of global beat i carries SEED ^ {i, 8'd0, k}.
  function automatic logic [DATA_W-1:0] pattern(input logic [15:0] idx);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[k*32 +: 32] = SEED ^ {idx, 8'd0, 8'(k)};
    end
    return d;
  endfunction

  assign w_hs       = m_axi_wvalid && m_axi_wready;
  assign b_hs       = m_axi_bready && m_axi_bvalid;
  assign r_hs       = m_axi_rready && m_axi_rvalid;
  assign last_beat  = (beat == AX_LEN);
  assign last_burst = (burst_idx == LAST_BURST);
  assign beat_pattern = pattern(gbeat);

  always_comb begin
    // NOTE: every branch-assigned signal gets a default first, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)         state_nxt = calib_done ? S_AW : S_WAIT_CAL;
      S_WAIT_CAL:     if (calib_done)    state_nxt = S_AW;
      S_AW:           if (m_axi_awready) state_nxt = S_W;
      S_W:            if (w_hs && last_beat) state_nxt = S_B;
      S_B:            if (b_hs)          state_nxt = last_burst ? S_AR : S_AW;
      S_AR:           if (m_axi_arready) state_nxt = S_R;
      S_R:            if (r_hs && last_beat) state_nxt = last_burst ? S_DONE : S_AR;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // The burst length is owned by the beat counter, so a missing or early rlast
  // is only an error and never shortens or stretches the burst.
  assign data_err  = r_hs && (m_axi_rdata != beat_pattern);
  assign rresp_err = r_hs && (m_axi_rresp != 2'b00);
  assign rlast_err = r_hs && (m_axi_rlast != last_beat);

  always_comb begin
    err_add  = 2'd0;
    err_beat = gbeat;
    if (b_hs && m_axi_bresp != 2'b00) begin
      err_add  = 2'd1;
      err_beat = gbeat - BURST_BEATS;
    end
    if (r_hs) begin
      err_add = {1'b0, data_err} + {1'b0, rresp_err} + {1'b0, rlast_err};
    end
  end

  assign err_sum = {1'b0, err_count} + {15'd0, err_add};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (sys_rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      beat           <= '0;
      gbeat          <= '0;
      burst_idx      <= '0;
      err_count      <= '0;
      first_err_beat <= 16'hFFFF;
      err_seen       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr           <= BASE_ADDR;
            beat           <= '0;
            gbeat          <= '0;
            burst_idx      <= '0;
            err_count      <= '0;
            first_err_beat <= 16'hFFFF;
            err_seen       <= 1'b0;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat  <= last_beat ? 8'd0 : beat + 8'd1;
            gbeat <= gbeat + 16'd1;
          end
        end
        S_B: begin
          if (b_hs) begin
            // Read-back restarts at the base of the region.
            if (last_burst) begin
              burst_idx <= '0;
              addr      <= BASE_ADDR;
              gbeat     <= '0;
            end else begin
              burst_idx <= burst_idx + 16'd1;
              addr      <= addr + BURST_STRIDE;
            end
          end
        end
        S_R: begin
          if (r_hs) begin
            beat  <= last_beat ? 8'd0 : beat + 8'd1;
            gbeat <= gbeat + 16'd1;
            if (last_beat) begin
              burst_idx <= burst_idx + 16'd1;
              addr      <= addr + BURST_STRIDE;
            end
          end
        end
        default: ;
      endcase

      if (err_add != 2'd0) begin
        err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (!err_seen) begin
          first_err_beat <= err_beat;
          err_seen       <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 16'd0);

  // Payloads are zero outside their own state, which keeps reset values clean.
  assign m_axi_awvalid = (state == S_AW);
  assign m_axi_awaddr  = m_axi_awvalid ? addr : '0;
  assign m_axi_awlen   = m_axi_awvalid ? AX_LEN : 8'd0;
  assign m_axi_awsize  = m_axi_awvalid ? AX_SIZE : 3'd0;
  assign m_axi_awburst = m_axi_awvalid ? 2'b01 : 2'b00;

  assign m_axi_wvalid  = (state == S_W);
  assign m_axi_wdata   = m_axi_wvalid ? beat_pattern : '0;
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast   = m_axi_wvalid && last_beat;

  assign m_axi_bready  = (state == S_B);

  assign m_axi_arvalid = (state == S_AR);
  assign m_axi_araddr  = m_axi_arvalid ? addr : '0;
  assign m_axi_arlen   = m_axi_arvalid ? AX_LEN : 8'd0;
  assign m_axi_arsize  = m_axi_arvalid ? AX_SIZE : 3'd0;
  assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;

  assign m_axi_rready  = (state == S_R);

endmodule

// File: tb/tb_ddr4_axi_traffic_gen.sv
// Bench for ddr4_axi_traffic_gen: memory-backed AXI slave model with fault
// injection, scenario table, and directed reset / calibration / restart sequences.
module tb_ddr4_axi_traffic_gen;

  localparam int          DATA_W = 256;
  localparam int          ADDR_W = 31;
  localparam int          BL     = 16;
  localparam int          NB     = 4;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic                clk = 1'b0;
  logic                sys_rst, start, calib_done;
  logic                busy, done, pass;
  logic [15:0]         err_count, first_err_beat;
  logic [ADDR_W-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [7:0]          m_axi_awlen, m_axi_arlen;
  logic [2:0]          m_axi_awsize, m_axi_arsize;
  logic [1:0]          m_axi_awburst, m_axi_arburst;
  logic                m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
  logic                m_axi_arvalid, m_axi_rready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic                m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
  logic [1:0]          m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [DATA_W-1:0]   m_axi_rdata = '0;

  ddr4_axi_traffic_gen dut (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start), .calib_done(calib_done),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_beat(first_err_beat),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    bp;
    int    corrupt_beat;
    int    rresp_beat;
    int    bresp_burst;
    int    early_burst;
    int    early_beat;
    int    nolast_burst;
    int    exp_err;
    int    exp_first;
    bit    exp_pass;
  } scen_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave configuration, written only by the stimulus process.
  bit cfg_bp = 1'b0;
  int cfg_corrupt = -1, cfg_rresp = -1, cfg_bresp = -1;
  int cfg_early_burst = -1, cfg_early_beat = 0, cfg_nolast = -1;

  // Slave model state and statistics, written only by the slave process.
  logic [DATA_W-1:0] mem [0:63];
  logic [ADDR_W-1:0] aw_log [0:255];
  int                wl_log [0:255];
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, wl_cnt = 0;
  int aw_bad = 0, ar_bad = 0, wr_bad = 0, stab_bad = 0;
  int w_base = 0, wbeat = 0, r_base = 0, r_idx = 0, b_burst = 0, gi = 0;
  bit r_active = 0, b_pending = 0, b_fire = 0, r_fire = 0;
  bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [ADDR_W-1:0] p_awaddr = '0, p_araddr = '0;
  logic [7:0]        p_awlen = '0, p_arlen = '0;
  logic [DATA_W-1:0] p_wdata = '0;
  logic              p_wlast = 1'b0;

  function automatic logic [DATA_W-1:0] pat(input int i);
    logic [DATA_W-1:0] d;
    logic [15:0]       i16;
    i16 = i[15:0];
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = SEED ^ {i16, 8'h00, 8'(k)};
    return d;
  endfunction

  function automatic logic rb();
    return cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Slave decisions are made on the falling edge; a transfer commits here when
  // valid and ready are both high, and the DUT sees it on the next rising edge.
  always @(negedge clk) begin
    if (sys_rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0;
      m_axi_rlast = 0; m_axi_rdata = '0;
      r_active = 0; b_pending = 0; b_fire = 0; r_fire = 0; wbeat = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr || m_axi_awlen !== p_awlen))
        stab_bad++;
      if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wlast !== p_wlast))
        stab_bad++;
      if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr || m_axi_arlen !== p_arlen))
        stab_bad++;

      if (b_fire) begin m_axi_bvalid = 0; m_axi_bresp = 0; b_pending = 0; end
      if (b_pending && !m_axi_bvalid) begin
        m_axi_bvalid = rb();
        m_axi_bresp  = (b_burst == cfg_bresp) ? 2'b10 : 2'b00;
      end
      b_fire = m_axi_bvalid && m_axi_bready;

      if (r_fire) begin
        r_idx++;
        m_axi_rvalid = 0;
        if (r_idx == BL) r_active = 0;
      end
      if (r_active && !m_axi_rvalid) m_axi_rvalid = rb();
      if (m_axi_rvalid) begin
        gi = r_base + r_idx;
        m_axi_rdata = mem[gi & 63];
        if (gi == cfg_corrupt) m_axi_rdata[96] = ~m_axi_rdata[96];
        m_axi_rresp = (gi == cfg_rresp) ? 2'b10 : 2'b00;
        m_axi_rlast = (r_idx == BL - 1);
        if (r_base / BL == cfg_early_burst && r_idx == cfg_early_beat) m_axi_rlast = 1;
        if (r_base / BL == cfg_nolast && r_idx == BL - 1) m_axi_rlast = 0;
      end else begin
        m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;
      end
      r_fire = m_axi_rvalid && m_axi_rready;

      m_axi_awready = rb();
      if (m_axi_awvalid && m_axi_awready) begin
        if (m_axi_awlen !== 8'(BL - 1) || m_axi_awsize !== 3'd5 || m_axi_awburst !== 2'b01) aw_bad++;
        aw_log[aw_cnt & 255] = m_axi_awaddr;
        aw_cnt++;
        w_base = int'(m_axi_awaddr >> 5);
        wbeat  = 0;
      end

      m_axi_wready = rb();
      if (m_axi_wvalid && m_axi_wready) begin
        gi = w_base + wbeat;
        if (m_axi_wdata !== pat(gi) || m_axi_wstrb !== '1 || m_axi_wlast !== (wbeat == BL - 1))
          wr_bad++;
        mem[gi & 63] = m_axi_wdata;
        w_cnt++;
        if (m_axi_wlast) begin wl_log[wl_cnt & 255] = gi; wl_cnt++; end
        if (wbeat == BL - 1) begin b_pending = 1; b_burst = w_base / BL; wbeat = 0; end
        else wbeat++;
      end

      m_axi_arready = rb();
      if (m_axi_arvalid && m_axi_arready) begin
        if (m_axi_arlen !== 8'(BL - 1) || m_axi_arsize !== 3'd5 || m_axi_arburst !== 2'b01) ar_bad++;
        r_base = int'(m_axi_araddr >> 5);
        r_idx = 0; r_active = 1;
        ar_cnt++;
      end

      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata  = m_axi_wdata;  p_wlast = m_axi_wlast;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr; p_arlen = m_axi_arlen;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20000) begin tick(); n++; end
    check({nm, "_done"}, done, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_pass"}, pass, 0);
    check({nm, "_err"}, err_count, 0);
    check({nm, "_first"}, first_err_beat, 16'hFFFF);
    check({nm, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    check({nm, "_readies"}, {m_axi_bready, m_axi_rready}, 0);
    check({nm, "_awaddr"}, m_axi_awaddr, 0);
    check({nm, "_awlen"}, m_axi_awlen, 0);
    check({nm, "_araddr"}, m_axi_araddr, 0);
    check({nm, "_wdata_nz"}, (m_axi_wdata != '0), 0);
    check({nm, "_wlast"}, m_axi_wlast, 0);
  endtask

  task automatic run_scen(input scen_t s);
    int aw0, ar0, w0, wb0, ab0, rb0, sb0;
    cfg_bp = s.bp; cfg_corrupt = s.corrupt_beat; cfg_rresp = s.rresp_beat;
    cfg_bresp = s.bresp_burst; cfg_early_burst = s.early_burst;
    cfg_early_beat = s.early_beat; cfg_nolast = s.nolast_burst;
    calib_done = 1'b1;
    aw0 = aw_cnt; ar0 = ar_cnt; w0 = w_cnt; wb0 = wr_bad; ab0 = aw_bad; rb0 = ar_bad; sb0 = stab_bad;
    pulse_start();
    check({s.nm, "_clr_err"}, err_count, 0);
    check({s.nm, "_clr_first"}, first_err_beat, 16'hFFFF);
    check({s.nm, "_busy"}, busy, 1);
    repeat (20) tick();
    calib_done = 1'b0;
    check({s.nm, "_busy_mid"}, busy, 1);
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_done(s.nm);
    calib_done = 1'b1;
    check({s.nm, "_err"}, err_count, s.exp_err);
    check({s.nm, "_first"}, first_err_beat, s.exp_first);
    check({s.nm, "_pass"}, pass, s.exp_pass);
    check({s.nm, "_busy_end"}, busy, 0);
    check({s.nm, "_aw_n"}, aw_cnt - aw0, NB);
    check({s.nm, "_ar_n"}, ar_cnt - ar0, NB);
    check({s.nm, "_w_n"}, w_cnt - w0, NB * BL);
    check({s.nm, "_wr_bad"}, wr_bad - wb0, 0);
    check({s.nm, "_ax_bad"}, (aw_bad - ab0) + (ar_bad - rb0), 0);
    check({s.nm, "_stable"}, stab_bad - sb0, 0);
    repeat (5) tick();
    check({s.nm, "_hold_done"}, {done, pass}, {1'b1, s.exp_pass});
  endtask

  initial begin
    scen_t tbl [7];
    int    early, aw0, w0, wl0, n;
    tbl[0] = '{"clean",    1'b0, -1, -1, -1, -1, 0, -1, 0, 'hFFFF, 1'b1};
    tbl[1] = '{"bp",       1'b1, -1, -1, -1, -1, 0, -1, 0, 'hFFFF, 1'b1};
    tbl[2] = '{"corrupt",  1'b0, 20, -1, -1, -1, 0, -1, 1, 20,     1'b0};
    tbl[3] = '{"resp",     1'b0, -1, -1,  2,  3, 5, -1, 2, 32,     1'b0};
    tbl[4] = '{"rresp_bp", 1'b1, 41, 40, -1, -1, 0, -1, 2, 40,     1'b0};
    tbl[5] = '{"nolast",   1'b0, -1, -1, -1, -1, 0,  1, 1, 31,     1'b0};
    tbl[6] = '{"repeat",   1'b0, -1, -1, -1, -1, 0, -1, 0, 'hFFFF, 1'b1};

    sys_rst = 1'b1; start = 1'b0; calib_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    sys_rst = 1'b0;
    tick();

    // Calibration gate: start accepted but no AW until calib_done rises.
    aw0 = aw_cnt; w0 = w_cnt; wl0 = wl_cnt;
    pulse_start();
    early = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (m_axi_awvalid) early++;
    end
    check("gate_awvalid_low", early, 0);
    check("gate_busy", busy, 1);
    calib_done = 1'b1;
    wait_done("gate");
    check("gate_aw_n", aw_cnt - aw0, NB);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("gate_awaddr%0d", b), aw_log[(aw0 + b) & 255], b * 512);
      check($sformatf("gate_wlast%0d", b), wl_log[(wl0 + b) & 255], b * BL + BL - 1);
    end
    check("gate_w_n", w_cnt - w0, 64);
    check("gate_aw_fields", aw_bad, 0);
    check("gate_wr_bad", wr_bad, 0);
    check("gate_pass", pass, 1);
    check("gate_err", err_count, 0);
    check("gate_first", first_err_beat, 16'hFFFF);

    // Reset asserted in the middle of a W burst.
    w0 = w_cnt;
    pulse_start();
    n = 0;
    while (w_cnt - w0 < 5 && n < 500) begin tick(); n++; end
    check("rstw_reached", (w_cnt - w0 >= 5), 1);
    check("rstw_in_w", m_axi_wvalid, 1);
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("rstw");
    repeat (3) tick();
    check_reset_outputs("rstw_hold");
    sys_rst = 1'b0;
    tick();

    for (int t = 0; t < 7; t++) run_scen(tbl[t]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
